// File: rtl/ram_arbiter_pkg.sv
// Shared types and widths for the two-port RAM arbiter.
package ram_arbiter_pkg;

   localparam int NPORT = 2;

   typedef enum logic [1:0] {
      IDLE,
      WR,
      RD1,
      RD2
   } state_t;

   typedef logic port_t;

   function automatic int beWidth(input int dw);
      return dw / 8;
   endfunction

   localparam int BEW = beWidth(16);

endpackage

// File: rtl/ram_arb_pick.sv
// Two-way grant picker: round-robin by default, fixed P0 priority when
// RAM_ARB_FIXED_PRIO_EN is defined.
module ram_arb_pick
   import ram_arbiter_pkg::*;
(
   input  logic [NPORT-1:0] eligible,
   input  port_t            last,
   output logic             valid,
   output port_t            grant
);

   assign valid = |eligible;

`ifdef RAM_ARB_FIXED_PRIO_EN
   assign grant = eligible[0] ? 1'b0 : 1'b1;
`else
   always_comb begin
      grant = eligible[1];
      if (&eligible) grant = ~last;
   end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between two REQ/ACK requesters.
// Optional build macro: RAM_ARB_FIXED_PRIO_EN (fixed P0 priority instead of round-robin).
//
// state | meaning
// IDLE  | RAM idle; pick an eligible port and latch its request
// WR    | write strobe presented to the RAM for one cycle
// RD1   | read address presented; RAM registers the word at the edge
// RD2   | RAM data valid; captured into the grantee's DO
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int AW = 16,
   parameter int DW = 16
)
(
   input  logic            CLK,
   input  logic            nRES,
   input  logic            P0_REQ,
   input  logic            P0_WE,
   input  logic [DW/8-1:0] P0_nBE,
   input  logic [AW-1:0]   P0_A,
   input  logic [DW-1:0]   P0_DI,
   output logic [DW-1:0]   P0_DO,
   output logic            P0_ACK,
   input  logic            P1_REQ,
   input  logic            P1_WE,
   input  logic [DW/8-1:0] P1_nBE,
   input  logic [AW-1:0]   P1_A,
   input  logic [DW-1:0]   P1_DI,
   output logic [DW-1:0]   P1_DO,
   output logic            P1_ACK,
   output logic            RAM_nCE,
   output logic            RAM_nWE,
   output logic            RAM_nOE,
   output logic [DW/8-1:0] RAM_nBE,
   output logic [AW-1:0]   RAM_A,
   output logic [DW-1:0]   RAM_DI,
   input  logic [DW-1:0]   RAM_DO
);

   localparam int BW = beWidth(DW);

   state_t            state, stateNext;
   port_t             grant, lastGrant, pickGrant;
   logic              pickValid;
   logic [NPORT-1:0]  eligible, ack, ackNext;
   logic              selWe;
   logic [BW-1:0]     selNBe, nBeNext;
   logic [AW-1:0]     selA;
   logic [DW-1:0]     selDi;
   logic              nCeNext, nWeNext, nOeNext;
   logic              grantLoad, doLoad;

   // A port whose ACK is high this cycle is masked so it cannot be regranted on a stale REQ.
   assign eligible = {P1_REQ & ~ack[1], P0_REQ & ~ack[0]};
   assign P0_ACK   = ack[0];
   assign P1_ACK   = ack[1];

   ram_arb_pick u_pick (
      .eligible (eligible),
      .last     (lastGrant),
      .valid    (pickValid),
      .grant    (pickGrant)
   );

   assign selWe  = pickGrant ? P1_WE  : P0_WE;
   assign selNBe = pickGrant ? P1_nBE : P0_nBE;
   assign selA   = pickGrant ? P1_A   : P0_A;
   assign selDi  = pickGrant ? P1_DI  : P0_DI;

   // RAM controls are registered from the next state, so they are valid for the whole state cycle.
   always_comb begin
      stateNext = state;
      nCeNext   = 1'b1;
      nWeNext   = 1'b1;
      nOeNext   = 1'b1;
      nBeNext   = '1;
      ackNext   = '0;
      grantLoad = 1'b0;
      doLoad    = 1'b0;
      case (state)
         IDLE: begin
            if (pickValid) begin
               grantLoad = 1'b1;
               nCeNext   = 1'b0;
               if (selWe) begin
                  stateNext = WR;
                  nWeNext   = 1'b0;
                  nBeNext   = selNBe;
               end else begin
                  stateNext = RD1;
                  nOeNext   = 1'b0;
               end
            end
         end
         WR: begin
            stateNext      = IDLE;
            ackNext[grant] = 1'b1;
         end
         RD1: begin
            stateNext = RD2;
            nCeNext   = 1'b0;
            nOeNext   = 1'b0;
         end
         RD2: begin
            stateNext      = IDLE;
            ackNext[grant] = 1'b1;
            doLoad         = 1'b1;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES) state <= IDLE;
      else       state <= stateNext;
   end

   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES) begin
         RAM_nCE   <= 1'b1;
         RAM_nWE   <= 1'b1;
         RAM_nOE   <= 1'b1;
         RAM_nBE   <= '1;
         RAM_A     <= '0;
         RAM_DI    <= '0;
         ack       <= '0;
         P0_DO     <= '0;
         P1_DO     <= '0;
         grant     <= 1'b0;
         lastGrant <= 1'b1;
      end else begin
         RAM_nCE <= nCeNext;
         RAM_nWE <= nWeNext;
         RAM_nOE <= nOeNext;
         RAM_nBE <= nBeNext;
         ack     <= ackNext;
         if (grantLoad) begin
            grant     <= pickGrant;
            lastGrant <= pickGrant;
            RAM_A     <= selA;
            RAM_DI    <= selDi;
         end
         if (doLoad) begin
            if (grant) P1_DO <= RAM_DO;
            else       P0_DO <= RAM_DO;
         end
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural synchronous RAM model.
module tb_ram_arbiter;

   logic        CLK = 1'b0;
   logic        nRES = 1'b0;
   logic        P0_REQ = 0, P0_WE = 0, P1_REQ = 0, P1_WE = 0;
   logic [1:0]  P0_nBE = '1, P1_nBE = '1;
   logic [15:0] P0_A = 0, P0_DI = 0, P1_A = 0, P1_DI = 0;
   logic [15:0] P0_DO, P1_DO;
   logic        P0_ACK, P1_ACK;
   logic        RAM_nCE, RAM_nWE, RAM_nOE;
   logic [1:0]  RAM_nBE;
   logic [15:0] RAM_A, RAM_DI, RAM_DO;

   ram_arbiter #(.AW(16), .DW(16)) dut (
      .CLK(CLK), .nRES(nRES),
      .P0_REQ(P0_REQ), .P0_WE(P0_WE), .P0_nBE(P0_nBE), .P0_A(P0_A), .P0_DI(P0_DI),
      .P0_DO(P0_DO), .P0_ACK(P0_ACK),
      .P1_REQ(P1_REQ), .P1_WE(P1_WE), .P1_nBE(P1_nBE), .P1_A(P1_A), .P1_DI(P1_DI),
      .P1_DO(P1_DO), .P1_ACK(P1_ACK),
      .RAM_nCE(RAM_nCE), .RAM_nWE(RAM_nWE), .RAM_nOE(RAM_nOE), .RAM_nBE(RAM_nBE),
      .RAM_A(RAM_A), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
   );

   always #5 CLK = ~CLK;

   // Synchronous RAM: write or registered read at the clock edge, output gated by nCE|nOE.
   logic [15:0] mem [0:65535];
   logic [15:0] ramQ = 16'h0;
   always @(posedge CLK) begin
      if (!RAM_nCE) begin
         if (!RAM_nWE) begin
            for (int b = 0; b < 2; b++)
               if (!RAM_nBE[b]) mem[RAM_A][b*8 +: 8] <= RAM_DI[b*8 +: 8];
         end else if (!RAM_nOE) begin
            ramQ <= mem[RAM_A];
         end
      end
   end
   assign RAM_DO = (RAM_nCE | RAM_nOE) ? 16'h0000 : ramQ;

   typedef struct {
      int          port;
      bit          rd;
      logic [15:0] data;
   } exp_t;

   exp_t        sbq[$];
   logic [15:0] refMem [int];
   logic [15:0] tbDo [2];
   int          tbLast;
   int          nTests = 0;
   int          nFail = 0;
   int          cyc = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                         input logic [1:0] nbe);
      logic [15:0] r;
      r = old;
      for (int b = 0; b < 2; b++)
         if (!nbe[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [15:0] refRead(input logic [15:0] a);
      return refMem.exists(int'(a)) ? refMem[int'(a)] : 16'h0;
   endfunction

   function automatic int pick(input logic [1:0] elig, input int last);
`ifdef RAM_ARB_FIXED_PRIO_EN
      return elig[0] ? 0 : 1;
`else
      if (elig == 2'b11) return 1 - last;
      return elig[1] ? 1 : 0;
`endif
   endfunction

   // Expected-transaction model: builds the scoreboard entry and updates the reference memory.
   function automatic exp_t expect_access(input int p, input logic we, input logic [1:0] nbe,
                                          input logic [15:0] a, input logic [15:0] di);
      exp_t e;
      e.port = p;
      e.rd   = !we;
      e.data = refRead(a);
      if (we) refMem[int'(a)] = merge(refRead(a), di, nbe);
      return e;
   endfunction

   task automatic setPort(input int p, input logic req, input logic we, input logic [1:0] nbe,
                          input logic [15:0] a, input logic [15:0] di);
      if (p == 0) begin
         P0_REQ = req; P0_WE = we; P0_nBE = nbe; P0_A = a; P0_DI = di;
      end else begin
         P1_REQ = req; P1_WE = we; P1_nBE = nbe; P1_A = a; P1_DI = di;
      end
   endtask

   // Monitor: every ACK pops one expectation.
   exp_t monE;
   int   monP;
   always @(negedge CLK) begin
      if (P0_ACK | P1_ACK) begin
         chk("ack_onehot", {P1_ACK, P0_ACK} == 2'b11, 0);
         monP = P1_ACK ? 1 : 0;
         chk("sb_nonempty", sbq.size() != 0, 1);
         if (sbq.size() != 0) begin
            monE = sbq.pop_front();
            chk("ack_port", monP, monE.port);
            if (monE.rd) begin
               chk("rd_data", monP ? P1_DO : P0_DO, monE.data);
               tbDo[monP] = monE.data;
            end
            chk("other_do", monP ? P0_DO : P1_DO, tbDo[1 - monP]);
            tbLast = monP;
         end
      end
   end

   // Single access from an idle arbiter; checks the strobe in cycle 1 and ACK latency.
   task automatic access(input int p, input logic we, input logic [1:0] nbe, input logic [15:0] a,
                         input logic [15:0] di, input int expLat, input string tag);
      int lat;
      sbq.push_back(expect_access(p, we, nbe, a, di));
      setPort(p, 1'b1, we, nbe, a, di);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge CLK); #1;
         if (i == 1) chk({tag, "_c1_nwe"}, RAM_nWE, !we);
         if ((p == 0) ? P0_ACK : P1_ACK) begin
            lat = i;
            break;
         end
      end
      if (p == 0) P0_REQ = 1'b0; else P1_REQ = 1'b0;
      chk({tag, "_latency"}, lat, expLat);
      @(posedge CLK); #1;
   endtask

   // Ports in reqs hold REQ until n ACKs; checks ACK spacing and count.
   task automatic holdRun(input logic [1:0] reqs, input logic we, input logic [15:0] a0,
                          input logic [15:0] a1, input logic [15:0] d0, input logic [15:0] d1,
                          input int n, input int expGap, input string tag);
      int prev, lastM, g, acks, lastCyc;
      logic [1:0] elig;
      prev = -1;
      lastM = tbLast;
      for (int k = 0; k < n; k++) begin
         elig = reqs;
         if (prev >= 0) elig[prev] = 1'b0;
         if (elig == 2'b00) elig = reqs;
         g = pick(elig, lastM);
         sbq.push_back(expect_access(g, we, 2'b00, g ? a1 : a0, g ? d1 : d0));
         lastM = g;
         prev = g;
      end
      if (reqs[0]) setPort(0, 1'b1, we, 2'b00, a0, d0);
      if (reqs[1]) setPort(1, 1'b1, we, 2'b00, a1, d1);
      acks = 0;
      lastCyc = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge CLK); #1;
         if (P0_ACK | P1_ACK) begin
            acks++;
            if (acks > 1) chk({tag, "_gap"}, cyc - lastCyc, expGap);
            lastCyc = cyc;
            if (acks == n) break;
         end
      end
      P0_REQ = 1'b0;
      P1_REQ = 1'b0;
      chk({tag, "_count"}, acks, n);
      @(posedge CLK); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbDo[0] = 16'h0;
      tbDo[1] = 16'h0;
      tbLast  = 1;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_ctl", {RAM_nCE, RAM_nWE, RAM_nOE, RAM_nBE}, 5'b11111);
      chk("rst_a", RAM_A, 0);
      chk("rst_di", RAM_DI, 0);
      chk("rst_ack", {P1_ACK, P0_ACK}, 0);
      chk("rst_do", {P1_DO, P0_DO}, 0);
      nRES = 1'b1;
      @(posedge CLK); #1;

      access(0, 1'b1, 2'b00, 16'h0012, 16'hBEEF, 2, "p0_wr");
      access(0, 1'b0, 2'b11, 16'h0012, 16'h0000, 3, "p0_rd");

      access(1, 1'b1, 2'b00, 16'h0040, 16'h1234, 2, "be_pre");
      access(1, 1'b1, 2'b10, 16'h0040, 16'hABCD, 2, "be_wr");
      access(1, 1'b0, 2'b11, 16'h0040, 16'h0000, 3, "be_rd");
      chk("be_value", P1_DO, 16'h12CD);

      access(0, 1'b1, 2'b00, 16'h0100, 16'h1111, 2, "pre0");
      access(1, 1'b1, 2'b00, 16'h0200, 16'h2222, 2, "pre1");
      holdRun(2'b11, 1'b0, 16'h0100, 16'h0200, 16'h0, 16'h0, 4, 3, "cont_rd");
      holdRun(2'b11, 1'b1, 16'h0100, 16'h0200, 16'h5555, 16'h6666, 4, 2, "cont_wr");
      holdRun(2'b01, 1'b1, 16'h0110, 16'h0000, 16'h7A7A, 16'h0, 2, 3, "solo_wr");
      holdRun(2'b01, 1'b0, 16'h0110, 16'h0000, 16'h0, 16'h0, 2, 4, "solo_rd");
      access(1, 1'b0, 2'b11, 16'h0100, 16'h0000, 3, "cont_rb");

      // P1 pulses REQ only while P0's write is in WR, so it is never sampled in IDLE.
      sbq.push_back(expect_access(0, 1'b1, 2'b00, 16'h0300, 16'h7777));
      setPort(0, 1'b1, 1'b1, 2'b00, 16'h0300, 16'h7777);
      @(posedge CLK); #1;
      chk("wd_in_wr", RAM_nWE, 0);
      setPort(1, 1'b1, 1'b0, 2'b11, 16'h0012, 16'h0000);
      @(posedge CLK); #1;
      P1_REQ = 1'b0;
      chk("wd_p0_ack", P0_ACK, 1);
      P0_REQ = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge CLK); #1;
         chk("wd_p1_noack", P1_ACK, 0);
      end

      // Reset while in RD1: the read is abandoned.
      setPort(0, 1'b1, 1'b0, 2'b11, 16'h0012, 16'h0000);
      @(posedge CLK); #1;
      chk("mid_rd1_noe", RAM_nOE, 0);
      nRES = 1'b0;
      #1;
      chk("mid_rst_ctl", {RAM_nCE, RAM_nOE}, 2'b11);
      chk("mid_rst_ack", {P1_ACK, P0_ACK}, 0);
      chk("mid_rst_do", P0_DO, 0);
      tbDo[0] = 16'h0;
      tbDo[1] = 16'h0;
      tbLast  = 1;
      P0_REQ  = 1'b0;
      @(posedge CLK); @(posedge CLK); #3;
      nRES = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge CLK); #1;
         chk("post_rst_noack", {P1_ACK, P0_ACK}, 0);
      end
      holdRun(2'b11, 1'b0, 16'h0012, 16'h0300, 16'h0, 16'h0, 2, 3, "post_rst_tie");

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one single-port synchronous `ram` instance (1-cycle registered read, tristated DO gated by nCE|nOE, active-low byte enables) between two requesters, e.g. CPU bus and DMA/video fetch.
- Per-port REQ/ACK handshake. Round-robin arbitration. Drives all RAM control and address from registers.
- Sits between the bus/DMA glue and the RAM instance in the memory subsystem.

Parameters:
- AW, 16, RAM address width in words; must match the RAM instance.
- DW, 16, data width; multiple of 8; BE width is DW/8.

Ports:
- CLK  in  1  system clock.
- nRES  in  1  asynchronous active-low reset.
- P0_REQ  in  1  port 0 request; held until P0_ACK.
- P0_WE  in  1  1 = write, 0 = read; stable while REQ.
- P0_nBE  in  DW/8  active-low byte enables for writes.
- P0_A  in  AW  word address.
- P0_DI  in  DW  write data.
- P0_DO  out  DW  read data; valid while P0_ACK=1 and held afterwards.
- P0_ACK  out  1  one-cycle completion pulse.
- P1_REQ, P1_WE, P1_nBE, P1_A, P1_DI, P1_DO, P1_ACK: same as port 0.
- RAM_nCE  out  1  RAM chip enable.
- RAM_nWE  out  1  RAM write enable.
- RAM_nOE  out  1  RAM output enable.
- RAM_nBE  out  DW/8  RAM byte enables.
- RAM_A  out  AW  RAM address.
- RAM_DI  out  DW  RAM write data.
- RAM_DO  in  DW  RAM read data.

Behaviour:
- Clock and reset: single clock CLK; reset nRES is asynchronous, active-low.
- Reset values: RAM_nCE=1, RAM_nWE=1, RAM_nOE=1, RAM_nBE=all 1, RAM_A=0, RAM_DI=0, Px_ACK=0, Px_DO=0, state=IDLE, last-grant=P1 (so P0 wins the first tie).
- FSM states: IDLE, WR, RD1, RD2.
- IDLE:
  - Eligible port = REQ=1 and ACK not high this cycle (the acked port's REQ is masked for one cycle).
  - If any port is eligible, latch grant, WE, nBE, A and DI, then go to WR or RD1.
- WR: RAM_nCE=0, RAM_nWE=0, RAM_nOE=1, RAM_nBE=latched nBE. Next state IDLE; grantee ACK=1 next cycle.
- RD1: RAM_nCE=0, RAM_nOE=0, RAM_nWE=1, RAM_nBE=all 1. Address is presented. Next state RD2.
- RD2:
  - Same controls and address as RD1.
  - Capture RAM_DO into the grantee's Px_DO.
  - Next state IDLE; grantee ACK=1 next cycle.
- All RAM outputs are inactive in IDLE (nCE=nWE=nOE=1, nBE=all 1). RAM_A and RAM_DI hold their last values.
- Latency from REQ sampled in IDLE at cycle 0:
  - Write: RAM write at the end of cycle 1; ACK in cycle 2.
  - Read: address in cycle 1; data captured at the end of cycle 2; ACK and DO in cycle 3.
- Throughput: a new grant is issued in the ACK cycle. Back-to-back throughput is one write per 2 cycles or one read per 3.
- Arbitration: when both ports are eligible, grant the port that was not last granted. A single eligible port is always granted. last-grant updates on each grant.
- Px_DO of the non-granted port is never modified.
- Requesters must not change WE/nBE/A/DI while REQ=1 and ACK=0. Behaviour under changing inputs is undefined; the arbiter uses only the values latched at grant.
- Reset mid-operation: all outputs return to reset values immediately. An in-flight access is abandoned with no ACK. A write is not performed if nRES is low at the WR clock edge.
- A REQ withdrawn before grant is legal. A REQ withdrawn after grant still completes and ACKs.

Optional Feature:
- Macro: RAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; P0 always wins ties (with the ACK-cycle mask still applied). Last-grant logic is removed.
- Undefined: round-robin as above.

Decomposition:
- Package ram_arbiter_pkg:
  - state_t enum {IDLE, WR, RD1, RD2}.
  - port_t (1-bit port index).
  - Localparams NPORT=2 and BEW=DW/8 as a derived width function.
- One sub-module, ram_arb_pick: combinational 2-way round-robin/fixed picker (inputs eligible[1:0] and last; outputs valid and grant). It is the only place the macro is evaluated.

Test Plan:
- Reset: nRES=0 mid-RD1 → RAM_nCE=1, RAM_nOE=1, ACKs 0 immediately; after release, no stale ACK.
- Single write: P0 write A=0x0012, DI=0xBEEF, nBE=2'b00 → RAM_nWE=0 in cycle 1, P0_ACK in cycle 2. Then P0 read A=0x0012 → P0_DO=0xBEEF with ACK in cycle 3.
- Byte enable: preload 0x1234; P1 write DI=0xABCD, nBE=2'b10 → readback 0x12CD.
- Contention: P0 and P1 both hold read REQ continuously → grants alternate P0,P1,P0,P1, one ACK every 3 cycles, and P1_DO is untouched during P0 ACKs.
- Fixed priority (macro defined): same stimulus → P0 is served whenever eligible; P1 is granted only in P0's ACK-masked cycles.
- Early withdrawal: P1 REQ pulsed one cycle while a P0 write is in WR → P1 is never granted and P1_ACK stays 0.
